// File: rtl/kasumi_key_schedule_if.sv
// kasumi_key_schedule_if: key intake and round-subkey handshake bundle for the KASUMI key scheduler.
interface kasumi_key_schedule_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         sk_valid;
    logic         sk_ready;
    logic [2:0]   sk_round;
    logic [15:0]  kl1, kl2, ko1, ko2, ko3, ki1, ki2, ki3;
    logic         done;

    modport master (
        output key_valid, key, sk_ready,
        input  key_ready, sk_valid, sk_round, kl1, kl2, ko1, ko2, ko3, ki1, ki2, ki3, done
    );
    modport slave (
        input  key_valid, key, sk_ready,
        output key_ready, sk_valid, sk_round, kl1, kl2, ko1, ko2, ko3, ki1, ki2, ki3, done
    );
endinterface

// File: rtl/kasumi_key_schedule.sv
// kasumi_key_schedule: emits ROUNDS KASUMI subkey sets per key from rotating K/K' word registers.
module kasumi_key_schedule #(
    parameter int             ROUNDS    = 8,
    parameter logic [127:0]   KEY_CONST = 128'h0123456789ABCDEFFEDCBA9876543210
) (
    input logic                  clk,
    input logic                  rst,
    kasumi_key_schedule_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic [15:0] k [8];
    logic [15:0] kp [8];
    logic [15:0] src [8];
    logic [15:0] srcp [8];
    logic        accept, advance, last;

    function automatic logic [15:0] rol(input logic [15:0] w, input int n);
        return 16'({w, w} >> (16 - n));
    endfunction

    assign accept  = state == IDLE && bus.key_valid;
    assign advance = state == RUN && bus.sk_ready;
    assign last    = bus.sk_round == 3'(ROUNDS - 1);

    // src[0] is always K_i of the set about to be registered: fresh key in IDLE, rotated regs in RUN
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            src[j]  = state == IDLE ? bus.key[127-16*j -: 16] : k[3'(j + 1)];
            srcp[j] = state == IDLE ? bus.key[127-16*j -: 16] ^ KEY_CONST[127-16*j -: 16] : kp[3'(j + 1)];
        end
    end

    always_comb begin
        state_next    = accept ? RUN : (advance && last) ? IDLE : state;
        bus.key_ready = state == IDLE;
        bus.sk_valid  = state == RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.done     <= 1'b0;
            bus.sk_round <= '0;
            bus.kl1      <= '0;
            bus.kl2      <= '0;
            bus.ko1      <= '0;
            bus.ko2      <= '0;
            bus.ko3      <= '0;
            bus.ki1      <= '0;
            bus.ki2      <= '0;
            bus.ki3      <= '0;
            for (int j = 0; j < 8; j++) begin
                k[j]  <= '0;
                kp[j] <= '0;
            end
        end else begin
            state    <= state_next;
            bus.done <= advance && last;
            if (accept || (advance && !last)) begin
                k            <= src;
                kp           <= srcp;
                bus.sk_round <= accept ? 3'd0 : bus.sk_round + 3'd1;
                bus.kl1      <= rol(src[0], 1);
                bus.kl2      <= srcp[2];
                bus.ko1      <= rol(src[1], 5);
                bus.ko2      <= rol(src[5], 8);
                bus.ko3      <= rol(src[6], 13);
                bus.ki1      <= srcp[4];
                bus.ki2      <= srcp[3];
                bus.ki3      <= srcp[7];
            end
        end
    end
endmodule

// File: tb/tb_kasumi_key_schedule.sv
// tb_kasumi_key_schedule: randomized checks of the key scheduler against a direct formula model.
module tb_kasumi_key_schedule;
    localparam logic [127:0] KC = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kasumi_key_schedule_if bus();
    kasumi_key_schedule dut (.clk(clk), .rst(rst), .bus(bus));

    int           checks = 0;
    int           errors = 0;
    logic [127:0] obs [16];
    logic [2:0]   rnd [16];
    int           nsets, stall_bad, done_seen, last_acc, done_at;
    logic         first_valid;
    logic [127:0] cur_set;

    assign cur_set = {bus.kl1, bus.kl2, bus.ko1, bus.ko2, bus.ko3, bus.ki1, bus.ki2, bus.ki3};

    logic [31:0] t1_tab [16] = '{32'h0000_0000, 32'h0100_89AB, 32'h0200_0000, 32'h0300_0000,
                                 32'h0400_0000, 32'h0500_FEDC, 32'h0600_CDEF, 32'h0700_3210,
                                 32'h1100_CDEF, 32'h1500_BA98, 32'h1600_FEDC, 32'h1700_0123,
                                 32'h7100_4567, 32'h7500_CDEF, 32'h7600_89AB, 32'h7700_7654};
    logic [31:0] t2_tab [5]  = '{32'h0000_0003, 32'h1700_8122, 32'h2400_3000, 32'h3300_0180, 32'h7200_0030};

    // word K_n of a key, n taken mod 8 into 1..8
    function automatic logic [15:0] kw(input logic [127:0] k, input int n);
        int m = (n - 1) % 8;
        return 16'(k >> (16 * (7 - m)));
    endfunction

    function automatic logic [15:0] rol(input logic [15:0] w, input int n);
        return 16'((w << n) | (w >> (16 - n)));
    endfunction

    function automatic logic [127:0] model(input logic [127:0] k, input int r);
        int i = r + 1;
        return {rol(kw(k, i), 1), kw(k, i + 2) ^ kw(KC, i + 2), rol(kw(k, i + 1), 5),
                rol(kw(k, i + 5), 8), rol(kw(k, i + 6), 13), kw(k, i + 4) ^ kw(KC, i + 4),
                kw(k, i + 3) ^ kw(KC, i + 3), kw(k, i + 7) ^ kw(KC, i + 7)};
    endfunction

    function automatic logic [15:0] fld(input logic [127:0] s, input int f);
        return 16'(s >> (16 * (7 - f)));
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one key through to done, recording accepted sets; stall stability is tallied, not judged.
    task automatic collect(input logic [127:0] k, input int pct);
        int cyc = 0;
        logic stalled = 1'b0;
        logic [127:0] held = '0;
        nsets = 0; stall_bad = 0; done_seen = 0; last_acc = -1; done_at = -1;
        bus.key = k;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        first_valid = bus.sk_valid;
        while (done_seen == 0 && cyc < 200) begin
            if (bus.done) begin
                done_seen = 1;
                done_at = cyc;
            end
            if (bus.sk_valid) begin
                if (stalled && cur_set !== held) stall_bad++;
                bus.sk_ready = $urandom_range(99) < pct;
                stalled = !bus.sk_ready;
                held = cur_set;
                if (bus.sk_ready && nsets < 16) begin
                    obs[nsets] = cur_set;
                    rnd[nsets] = bus.sk_round;
                    nsets++;
                    last_acc = cyc;
                end
            end else bus.sk_ready = 1'($urandom_range(1));
            @(negedge clk);
            cyc++;
        end
        bus.sk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.sk_ready = 1'b0;
        bus.key = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.key_ready !== 1'b1 || bus.sk_valid !== 1'b0 || bus.done !== 1'b0 || bus.sk_round !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctl ready=%b valid=%b done=%b round=%0d want 1 0 0 0",
                     bus.key_ready, bus.sk_valid, bus.done, bus.sk_round);
        end
        checks++;
        if (cur_set !== '0) begin
            errors++;
            $display("FAIL reset_subkeys got %h want 0", cur_set);
        end
    endtask

    task automatic test_zero_key();
        collect('0, 100);
        checks++;
        if (nsets !== 8 || first_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_key_count sets=%0d first_valid=%b want 8 1", nsets, first_valid);
        end
        checks++;
        if (done_seen !== 1 || done_at - last_acc !== 1) begin
            errors++;
            $display("FAIL zero_key_done seen=%0d gap=%0d want 1 1", done_seen, done_at - last_acc);
        end
        for (int j = 0; j < 16; j++) begin
            logic [31:0] e = t1_tab[j];
            checks++;
            if (fld(obs[e[31:28]], int'(e[27:24])) !== e[15:0]) begin
                errors++;
                $display("FAIL zero_key_vec r%0d f%0d got %h want %h", e[31:28] + 1, e[27:24],
                         fld(obs[e[31:28]], int'(e[27:24])), e[15:0]);
            end
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (obs[r] !== model('0, r) || rnd[r] !== 3'(r)) begin
                errors++;
                $display("FAIL zero_key_set r%0d got %h round %0d want %h round %0d", r + 1, obs[r], rnd[r], model('0, r), r);
            end
        end
    endtask

    task automatic test_single_bit_key();
        logic [127:0] k = 128'h8001 << 112;
        collect(k, 100);
        for (int j = 0; j < 5; j++) begin
            logic [31:0] e = t2_tab[j];
            checks++;
            if (fld(obs[e[31:28]], int'(e[27:24])) !== e[15:0]) begin
                errors++;
                $display("FAIL bit_key_vec r%0d f%0d got %h want %h", e[31:28] + 1, e[27:24],
                         fld(obs[e[31:28]], int'(e[27:24])), e[15:0]);
            end
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (obs[r] !== model(k, r)) begin
                errors++;
                $display("FAIL bit_key_set r%0d got %h want %h", r + 1, obs[r], model(k, r));
            end
        end
    endtask

    task automatic test_stall();
        for (int t = 0; t < 5; t++) begin
            logic [127:0] k = t == 0 ? '0 : rand_key();
            collect(k, 50);
            checks++;
            if (stall_bad !== 0 || nsets !== 8 || done_seen !== 1) begin
                errors++;
                $display("FAIL stall_run%0d unstable=%0d sets=%0d done=%0d want 0 8 1", t, stall_bad, nsets, done_seen);
            end
            for (int r = 0; r < 8; r++) begin
                checks++;
                if (obs[r] !== model(k, r) || rnd[r] !== 3'(r)) begin
                    errors++;
                    $display("FAIL stall_set run%0d r%0d got %h round %0d want %h round %0d",
                             t, r + 1, obs[r], rnd[r], model(k, r), r);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] k = rand_key();
        int cyc = 0;
        bus.key = k;
        bus.key_valid = 1'b1;
        bus.sk_ready = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        while (!(bus.sk_valid && bus.sk_round == 3'd3) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 20) begin
            errors++;
            $display("FAIL midrst_reach round=%0d valid=%b want round 3 valid", bus.sk_round, bus.sk_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.sk_valid !== 1'b0 || bus.key_ready !== 1'b1 || bus.done !== 1'b0 || bus.sk_round !== 3'd0 || cur_set !== '0) begin
            errors++;
            $display("FAIL midrst_state valid=%b ready=%b done=%b round=%0d set=%h want 0 1 0 0 0",
                     bus.sk_valid, bus.key_ready, bus.done, bus.sk_round, cur_set);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.sk_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet done=%b valid=%b want 0 0", bus.done, bus.sk_valid);
            end
        end
        bus.sk_ready = 1'b0;
        k = rand_key();
        collect(k, 100);
        checks++;
        if (nsets !== 8 || obs[0] !== model(k, 0) || rnd[0] !== 3'd0) begin
            errors++;
            $display("FAIL midrst_restart sets=%0d r1=%h round=%0d want 8 %h 0", nsets, obs[0], rnd[0], model(k, 0));
        end
    endtask

    // key_valid stays high throughout; the key changes to junk during RUN and must be ignored
    task automatic test_back_to_back();
        logic [127:0] keys [3];
        for (int s = 0; s < 3; s++) keys[s] = rand_key();
        bus.key = keys[0];
        bus.key_valid = 1'b1;
        bus.sk_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 27; c++) begin
            int s = c / 9;
            int p = c % 9;
            checks++;
            if (p < 8) begin
                if (bus.sk_valid !== 1'b1 || bus.sk_round !== 3'(p) || cur_set !== model(keys[s], p) ||
                    bus.done !== 1'b0 || bus.key_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_set k%0d r%0d valid=%b round=%0d done=%b ready=%b got %h want %h",
                             s, p + 1, bus.sk_valid, bus.sk_round, bus.done, bus.key_ready, cur_set, model(keys[s], p));
                end
                bus.key = rand_key();
            end else begin
                if (bus.sk_valid !== 1'b0 || bus.done !== 1'b1 || bus.key_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gap k%0d valid=%b done=%b ready=%b want 0 1 1", s, bus.sk_valid, bus.done, bus.key_ready);
                end
                if (s < 2) bus.key = keys[s + 1];
                else bus.key_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (bus.key_ready !== 1'b1 || bus.sk_valid !== 1'b0 || bus.done !== 1'b0 || cur_set !== model(keys[2], 7)) begin
            errors++;
            $display("FAIL idle_hold ready=%b valid=%b done=%b set=%h want 1 0 0 %h",
                     bus.key_ready, bus.sk_valid, bus.done, cur_set, model(keys[2], 7));
        end
        bus.sk_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_single_bit_key();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
